// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC scheduler: FSM encoding,
// default multiplier latency and product extension to accumulator width.
package mac_pkg;

    localparam int MUL_LAT_DEF = 1;
    localparam int EXT_W       = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // p holds a pw-bit product in its low bits; the result is sign- or
    // zero-extended to EXT_W and the caller keeps the low ACC_W bits.
    function automatic logic [EXT_W-1:0] ext_product(input logic [EXT_W-1:0] p,
                                                     input int unsigned      pw,
                                                     input logic             sgn);
        logic [EXT_W-1:0] mask;
        logic             neg;
        mask = (EXT_W'(1) << pw) - EXT_W'(1);
        neg  = sgn & (((p >> (pw - 1)) & EXT_W'(1)) != '0);
        return neg ? (p | ~mask) : (p & mask);
    endfunction

endpackage

// File: rtl/mac_lat_tracker.sv
// Follows each multiplier load through a MUL_LAT-deep tag pipe and keeps
// a count of accepted pairs whose products have not yet been accumulated.
module mac_lat_tracker
    import mac_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_i,
    input  logic pulse_i,
    output logic ret_fire_o,
    output logic drained_o
);

    logic [MUL_LAT-1:0] tag_q;
    logic [MUL_LAT-1:0] tag_d;
    logic [MUL_LAT:0]   tag_w;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign tag_w      = {tag_q, pulse_i};
    assign tag_d      = tag_w[MUL_LAT-1:0];
    assign ret_fire_o = tag_w[MUL_LAT];

    // Simultaneous issue and return cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (issue_i && !ret_fire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue_i && ret_fire_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign drained_o = (cnt_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_dot_scheduler.sv
// Streams cfg_len operand pairs into an external pipelined multiplier and
// accumulates the returning products into a dot-product result.
module mac_dot_scheduler
    import mac_pkg::*;
#(
    parameter int DATA_A   = 8,
    parameter int DATA_B   = 8,
    parameter bit SIGNED_A = 1'b0,
    parameter bit SIGNED_B = 1'b0,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int LEN_W    = 8,
    parameter int ACC_W    = DATA_A + DATA_B + LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_A-1:0]        in_a,
    input  logic [DATA_B-1:0]        in_b,
    output logic [DATA_A-1:0]        mul_a,
    output logic [DATA_B-1:0]        mul_b,
    output logic                     mul_pulse,
    input  logic [DATA_A+DATA_B-1:0] mul_p,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data
);

    localparam int PW = DATA_A + DATA_B;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_A-1:0] mul_a_q;
    logic [DATA_B-1:0] mul_b_q;
    logic              mul_pulse_q;
    logic              accept;
    logic              ret_fire;
    logic              drained;
    logic [EXT_W-1:0]  prod_ext;

    assign in_ready = (state_q == ST_ISSUE) && (issued_q < len_q);
    assign accept   = in_valid && in_ready;
    assign prod_ext = ext_product({{(EXT_W-PW){1'b0}}, mul_p}, PW, SIGNED_A | SIGNED_B);

    generate
        if (ACC_W < EXT_W) begin : g_ext_hi
            logic unused_ext_hi;
            assign unused_ext_hi = ^prod_ext[EXT_W-1:ACC_W];
        end
    endgenerate

    mac_lat_tracker #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (LEN_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (accept),
        .pulse_i    (mul_pulse_q),
        .ret_fire_o (ret_fire),
        .drained_o  (drained)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        acc_d    = acc_q;
        if (ret_fire) begin
            acc_d = acc_q + prod_ext[ACC_W-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = cfg_len;
                    issued_d = '0;
                    acc_d    = '0;
                    state_d  = (cfg_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            acc_q       <= acc_d;
            mul_pulse_q <= accept;
            if (accept) begin
                mul_a_q <= in_a;
                mul_b_q <= in_b;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_pulse = mul_pulse_q;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = acc_q;

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Directed bench for mac_dot_scheduler: an unsigned MUL_LAT=1 instance and a
// signed MUL_LAT=3 instance, each driving a behavioural multiplier pipeline.
module tb_mac_dot_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_u, start_s;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [7:0]  in_a, in_b;
    logic        res_ready;

    logic        busy_u, in_ready_u, mul_pulse_u, res_valid_u;
    logic [7:0]  mul_a_u, mul_b_u;
    logic [15:0] mul_p_u;
    logic [23:0] res_data_u;

    logic        busy_s, in_ready_s, mul_pulse_s, res_valid_s;
    logic [7:0]  mul_a_s, mul_b_s;
    logic [15:0] mul_p_s;
    logic [23:0] res_data_s;

    logic [7:0]  va [256];
    logic [7:0]  vb [256];

    int cyc = 0;
    int npu = 0;
    int nps = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_dot_scheduler u_dut_u (
        .clk(clk), .rst(rst), .start(start_u), .cfg_len(cfg_len), .busy(busy_u),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a_u), .mul_b(mul_b_u), .mul_pulse(mul_pulse_u), .mul_p(mul_p_u),
        .res_valid(res_valid_u), .res_ready(res_ready), .res_data(res_data_u)
    );

    mac_dot_scheduler #(.SIGNED_A(1'b1), .SIGNED_B(1'b1), .MUL_LAT(3)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_s), .cfg_len(cfg_len), .busy(busy_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a_s), .mul_b(mul_b_s), .mul_pulse(mul_pulse_s), .mul_p(mul_p_s),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s)
    );

    // Behavioural multipliers: product appears MUL_LAT cycles after the load cycle.
    logic [15:0] prod_u, ps0, ps1, ps2;
    logic signed [15:0] prod_s;
    assign prod_u = {8'd0, mul_a_u} * {8'd0, mul_b_u};
    assign prod_s = $signed({{8{mul_a_s[7]}}, mul_a_s}) * $signed({{8{mul_b_s[7]}}, mul_b_s});
    assign mul_p_s = ps2;

    always @(posedge clk) begin
        mul_p_u <= prod_u;
        ps0     <= prod_s;
        ps1     <= ps0;
        ps2     <= ps1;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mul_pulse_u) npu = npu + 1;
        if (mul_pulse_s) nps = nps + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit s, input logic [7:0] len, output int t0);
        cfg_len = len;
        if (s) start_s = 1'b1;
        else   start_u = 1'b1;
        tick();
        t0 = cyc;
        start_u = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic stream(input bit s, input int n, input logic [15:0] gaps);
        int   idx = 0;
        int   c = 0;
        logic acc;
        while (idx < n && c < 600) begin
            in_valid = (c < 16) ? !gaps[c[3:0]] : 1'b1;
            in_a     = va[idx];
            in_b     = vb[idx];
            acc      = in_valid && (s ? in_ready_s : in_ready_u);
            tick();
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0;
        chk("stream_accepted", idx, n);
    endtask

    task automatic wait_res(input bit s, output int t1);
        int c = 0;
        while (!(s ? res_valid_s : res_valid_u) && c < 400) begin
            tick();
            c++;
        end
        t1 = cyc;
        chk("res_valid_seen", {31'd0, (s ? res_valid_s : res_valid_u)}, 1);
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int   t0, t1, base;
        logic stable;
        rst = 1'b1;
        start_u = 1'b0; start_s = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, busy_u}, 0);
        chk("rst_in_ready", {31'd0, in_ready_u}, 0);
        chk("rst_mul_pulse", {31'd0, mul_pulse_u}, 0);
        chk("rst_res_valid", {31'd0, res_valid_u}, 0);
        chk("rst_res_data", {8'd0, res_data_u}, 0);
        chk("rst_mul_a", {24'd0, mul_a_u}, 0);
        rst = 1'b0;
        tick();

        // Unsigned, len 4, back-to-back: 2+12+30+56 = 100
        va[0] = 8'd1; va[1] = 8'd3; va[2] = 8'd5; va[3] = 8'd7;
        vb[0] = 8'd2; vb[1] = 8'd4; vb[2] = 8'd6; vb[3] = 8'd8;
        base = npu;
        do_start(1'b0, 8'd4, t0);
        chk("t1_busy", {31'd0, busy_u}, 1);
        chk("t1_in_ready", {31'd0, in_ready_u}, 1);
        stream(1'b0, 4, 16'h0000);
        wait_res(1'b0, t1);
        chk("t1_latency", t1 - t0, 6);
        chk("t1_res_data", {8'd0, res_data_u}, 100);
        chk("t1_pulses", npu - base, 4);
        tick();
        tick();
        chk("t1_hold_valid", {31'd0, res_valid_u}, 1);
        chk("t1_hold_data", {8'd0, res_data_u}, 100);
        handshake();
        chk("t1_valid_drop", {31'd0, res_valid_u}, 0);
        chk("t1_idle", {31'd0, busy_u}, 0);
        tick();
        chk("t1_single_window", {31'd0, res_valid_u}, 0);

        // Signed, MUL_LAT 3: -5 - 16256 + 16384 = 123
        va[0] = 8'hFF; va[1] = 8'h7F; va[2] = 8'h80;
        vb[0] = 8'h05; vb[1] = 8'h80; vb[2] = 8'h80;
        base = nps;
        do_start(1'b1, 8'd3, t0);
        stream(1'b1, 3, 16'h0000);
        wait_res(1'b1, t1);
        chk("t2_latency", t1 - t0, 7);
        chk("t2_res_data", {8'd0, res_data_s}, 123);
        chk("t2_pulses", nps - base, 3);
        handshake();
        chk("t2_idle", {31'd0, busy_s}, 0);

        // Gapped input and stalled result: 6 + 20 + 42 = 68
        va[0] = 8'd2; va[1] = 8'd4; va[2] = 8'd6;
        vb[0] = 8'd3; vb[1] = 8'd5; vb[2] = 8'd7;
        base = npu;
        do_start(1'b0, 8'd3, t0);
        stream(1'b0, 3, 16'b01010);
        wait_res(1'b0, t1);
        chk("t3_res_data", {8'd0, res_data_u}, 68);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stable = stable & (res_data_u == 24'd68) & busy_u & res_valid_u;
        end
        chk("t3_stable_while_stalled", {31'd0, stable}, 1);
        chk("t3_pulses", npu - base, 3);
        handshake();
        chk("t3_idle", {31'd0, busy_u}, 0);

        // Zero-length job, then start during DONE is ignored
        base = npu;
        do_start(1'b0, 8'd0, t0);
        chk("t4_done_valid", {31'd0, res_valid_u}, 1);
        chk("t4_res_data", {8'd0, res_data_u}, 0);
        chk("t4_busy", {31'd0, busy_u}, 1);
        cfg_len = 8'd5;
        start_u = 1'b1;
        tick();
        start_u = 1'b0;
        chk("t4_start_ignored_valid", {31'd0, res_valid_u}, 1);
        chk("t4_start_ignored_ready", {31'd0, in_ready_u}, 0);
        handshake();
        chk("t4_idle", {31'd0, busy_u}, 0);
        chk("t4_in_ready", {31'd0, in_ready_u}, 0);
        chk("t4_pulses", npu - base, 0);

        // Reset during DRAIN with three products outstanding
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'(i + 1);
            vb[i] = 8'd1;
        end
        do_start(1'b1, 8'd8, t0);
        stream(1'b1, 8, 16'h0000);
        tick();
        chk("t5_draining", {30'd0, busy_s, in_ready_s}, 2);
        chk("t5_partial_sum", {8'd0, res_data_s}, 15);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", {31'd0, busy_s}, 0);
        chk("t5_rst_mul_a", {24'd0, mul_a_s}, 0);
        chk("t5_rst_res_valid", {31'd0, res_valid_s}, 0);
        chk("t5_rst_res_data", {8'd0, res_data_s}, 0);
        tick();
        tick();
        rst = 1'b0;
        va[0] = 8'd2; va[1] = 8'd3;
        vb[0] = 8'd2; vb[1] = 8'd3;
        do_start(1'b1, 8'd2, t0);
        stream(1'b1, 2, 16'h0000);
        wait_res(1'b1, t1);
        chk("t5_latency", t1 - t0, 6);
        chk("t5_res_data", {8'd0, res_data_s}, 13);
        handshake();

        // Full-length job at maximum operands: 255 * 65025, no wrap
        for (int i = 0; i < 256; i++) begin
            va[i] = 8'hFF;
            vb[i] = 8'hFF;
        end
        base = npu;
        do_start(1'b0, 8'd255, t0);
        stream(1'b0, 255, 16'h0000);
        wait_res(1'b0, t1);
        chk("t6_latency", t1 - t0, 257);
        chk("t6_res_data", {8'd0, res_data_u}, 16581375);
        chk("t6_pulses", npu - base, 255);
        handshake();
        chk("t6_idle", {31'd0, busy_u}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_dot_scheduler.md
Name: mac_dot_scheduler

Overview:
- Sequences one pipelined multiplier instance to compute a dot product of cfg_len operand pairs.
- Pulls pairs from a valid/ready stream and issues each with a one-cycle mul_pulse.
- Tracks multiplier latency with a tag pipeline, accumulates each returning product, and presents the sum on a valid/ready result port.
- Sits between the operand fetch buffers and the multiplier in the accelerator MAC array.

Parameters:
- DATA_A, 8, width of operand A
- DATA_B, 8, width of operand B
- SIGNED_A, 0, 1 = operand A is two's complement
- SIGNED_B, 0, 1 = operand B is two's complement
- MUL_LAT, 1, cycles from a mul_pulse cycle until mul_p shows that product (>=1)
- LEN_W, 8, width of cfg_len
- ACC_W, DATA_A+DATA_B+LEN_W, accumulator/result width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a job, sampled in IDLE only
- cfg_len  in  LEN_W  number of pairs, latched on an accepted start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid&in_ready
- in_a  in  DATA_A  operand A
- in_b  in  DATA_B  operand B
- mul_a  out  DATA_A  multiplier operand A, registered
- mul_b  out  DATA_B  multiplier operand B, registered
- mul_pulse  out  1  multiplier load strobe, registered
- mul_p  in  DATA_A+DATA_B  multiplier product
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid&res_ready
- res_data  out  ACC_W  dot-product result

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0, accumulator 0, tag pipe cleared. rst mid-job aborts it; no result is produced.
- States:
  - IDLE -> ISSUE on start when cfg_len!=0.
  - IDLE -> DONE on start when cfg_len==0; res_data=0 and no pulse is issued.
  - ISSUE -> DRAIN on the cycle the cfg_len-th pair is accepted.
  - DRAIN -> DONE when the outstanding count reaches 0.
  - DONE -> IDLE on res_valid&res_ready.
- start outside IDLE is ignored.
- Issue:
  - in_ready = (state==ISSUE) & (issued < len).
  - An accepted pair registers in_a/in_b onto mul_a/mul_b with mul_pulse=1 in the next cycle.
  - mul_pulse is 0 whenever no pair was accepted.
  - Back-to-back issue rate is 1 pair per cycle; gaps in in_valid insert bubbles.
- Return:
  - Tag shift register of depth MUL_LAT shifts every cycle and carries mul_pulse.
  - When the tag output is 1, mul_p is the product for that issue and is accumulated in the same cycle.
  - An outstanding counter increments on issue and decrements on return; issue and return in the same cycle leave it unchanged.
- Arithmetic:
  - mul_p is sign-extended to ACC_W if SIGNED_A|SIGNED_B, otherwise zero-extended.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
  - The accumulator clears on an accepted start.
- Result:
  - res_valid=1 and res_data=accumulator throughout DONE; both are stable until the handshake.
  - res_valid drops the cycle after the handshake.
- Latency: a job of N>0 pairs presented every cycle from the cycle after start gives res_valid at cycle start+N+MUL_LAT+2.

Decomposition:
- Shared package mac_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, DONE)
  - function for product extension to ACC_W given SIGNED_A/SIGNED_B
  - default MUL_LAT constant
- One sub-module, mac_lat_tracker: the MUL_LAT-deep tag pipe plus outstanding counter, with a ret_fire output.
- The multiplier itself is instantiated by the parent, not inside this block.

Test Plan:
- Unsigned, MUL_LAT=1, len=4, pairs (1,2),(3,4),(5,6),(7,8) streamed back-to-back -> exactly 4 mul_pulse cycles, res_data=100, single res_valid window.
- SIGNED_A=SIGNED_B=1, MUL_LAT=3, len=3, pairs (-1,5),(127,-128),(-128,-128) -> res_data=-5-16256+16384=123, sign-extended to ACC_W.
- len=3 with in_valid toggling 1,0,1,0,1 and res_ready held low 5 cycles -> 3 pulses only, res_data constant while waiting, busy=1 until the handshake.
- cfg_len=0 start -> DONE next cycle, res_data=0, mul_pulse never asserted; start asserted during DONE is ignored.
- rst pulsed during DRAIN of a len=8 job with 3 products outstanding -> outputs 0 immediately; a following len=2 job (2,2),(3,3) gives res_data=13, unaffected by stale mul_p.
- Unsigned 8x8, LEN_W=8, len=255, all pairs (255,255) -> res_data=255*65025=16581375 in 24-bit ACC_W, with no wrap.
